// File: rtl/matrix_transfer_sequencer_pkg.sv
// mpu_pkg: geometry constants plus command and FSM encodings shared by the matrix transfer sequencer.
package mpu_pkg;
  localparam int ELEM_W      = 8;
  localparam int DIM         = 5;
  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 6;
  localparam int MATRIX_BITS = DIM * DIM * ELEM_W;
  localparam int WORDS       = (MATRIX_BITS + WORD_W - 1) / WORD_W;
  // Valid bits in the final word; they sit in the upper part of that word.
  localparam int LAST_W      = MATRIX_BITS - (WORDS - 1) * WORD_W;

  typedef enum logic [1:0] {
    OP_LOAD_A  = 2'd0,
    OP_LOAD_B  = 2'd1,
    OP_STORE_C = 2'd2
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/matrix_transfer_sequencer_word_slice.sv
// Combinational word-k view of a matrix: extract (last word left-aligned, zero padded) and insert.
module matrix_word_slice
  import mpu_pkg::*;
(
  input  logic [MATRIX_BITS-1:0] vec_i,
  input  logic [3:0]             k_i,
  input  logic [WORD_W-1:0]      word_i,
  output logic [WORD_W-1:0]      word_o,
  output logic [MATRIX_BITS-1:0] merged_o
);
  localparam logic [3:0] K_LAST = 4'(WORDS - 1);

  always_comb begin
    word_o   = '0;
    merged_o = vec_i;
    if (k_i == K_LAST) begin
      word_o = {vec_i[MATRIX_BITS-1 -: LAST_W], {(WORD_W - LAST_W){1'b0}}};
      merged_o[MATRIX_BITS-1 -: LAST_W] = word_i[WORD_W-1 -: LAST_W];
    end else if (k_i < K_LAST) begin
      word_o = vec_i[k_i*WORD_W +: WORD_W];
      merged_o[k_i*WORD_W +: WORD_W] = word_i;
    end
  end
endmodule

// File: rtl/matrix_transfer_sequencer.sv
// Moves a whole 200-bit matrix to/from 13 memory words, one MMU start/done handshake per word plus a gap cycle.
// Commands only accepted in IDLE (no queueing); STORE_C exists only with MATRIX_SEQ_STORE_EN defined.
module matrix_transfer_sequencer
  import mpu_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_W-1:0]      cmd_base,
  output logic                   mem_start,
  output logic                   mem_write_enabled,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [WORD_W-1:0]      mem_data_in,
  input  logic [WORD_W-1:0]      mem_data_out,
  input  logic                   mem_done,
  input  logic [MATRIX_BITS-1:0] matrix_c,
  output logic [MATRIX_BITS-1:0] matrix_a,
  output logic [MATRIX_BITS-1:0] matrix_b,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_GAP  = ST_GAP;
  localparam logic [1:0] S_DONE = ST_DONE;
  localparam logic [3:0] K_LAST = 4'(WORDS - 1);

  logic [1:0]             state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [3:0]             k_q, k_d;
  logic [MATRIX_BITS-1:0] a_q, a_d, b_q, b_d;
  logic                   err_q, err_d;
  logic                   op_legal;
  logic [MATRIX_BITS-1:0] slice_vec, merged;
  logic [WORD_W-1:0]      store_word;

`ifdef MATRIX_SEQ_STORE_EN
  logic [MATRIX_BITS-1:0] shadow_q, shadow_d;

  assign op_legal  = (cmd_op == OP_LOAD_A) || (cmd_op == OP_LOAD_B) || (cmd_op == OP_STORE_C);
  assign slice_vec = (op_q == OP_STORE_C) ? shadow_q : ((op_q == OP_LOAD_B) ? b_q : a_q);
  assign shadow_d  = (cmd_valid && (state_q == S_IDLE) && (cmd_op == OP_STORE_C)) ? matrix_c : shadow_q;
  assign mem_write_enabled = (state_q == S_REQ) && (op_q == OP_STORE_C);
  assign mem_data_in       = store_word;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) shadow_q <= '0;
    else          shadow_q <= shadow_d;
  end
`else
  logic unused_store_word;

  assign op_legal  = (cmd_op == OP_LOAD_A) || (cmd_op == OP_LOAD_B);
  assign slice_vec = (op_q == OP_LOAD_B) ? b_q : a_q;
  assign mem_write_enabled = 1'b0;
  assign mem_data_in       = '0;
  // Extract path has no consumer when stores are compiled out.
  assign unused_store_word = ^store_word;
`endif

  matrix_word_slice u_slice (
    .vec_i    (slice_vec),
    .k_i      (k_q),
    .word_i   (mem_data_out),
    .word_o   (store_word),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (op_legal) begin
            state_d = S_REQ;
            op_d    = cmd_op;
            base_d  = cmd_base;
            k_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_done) begin
          if (op_q == OP_LOAD_A)      a_d = merged;
          else if (op_q == OP_LOAD_B) b_d = merged;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      base_q  <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  // Address wraps modulo 64 through the natural ADDR_W-bit add.
  assign mem_address = base_q + ADDR_W'(k_q);
  assign mem_start   = (state_q == S_REQ);
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign matrix_a    = a_q;
  assign matrix_b    = b_q;
endmodule

// File: tb/tb_matrix_transfer_sequencer.sv
// Randomized bench for matrix_transfer_sequencer with a flag-level reference model and per-cycle compare.
module tb_matrix_transfer_sequencer;
  localparam int NW = 13;

  logic         clock, reset_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [5:0]   cmd_base;
  logic         mem_start, mem_write_enabled, mem_done;
  logic [5:0]   mem_address;
  logic [15:0]  mem_data_in, mem_data_out;
  logic [199:0] matrix_c, matrix_a, matrix_b;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  matrix_transfer_sequencer dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .mem_start(mem_start),
    .mem_write_enabled(mem_write_enabled), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_done(mem_done),
    .matrix_c(matrix_c), .matrix_a(matrix_a), .matrix_b(matrix_b),
    .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [199:0] put_word(input logic [199:0] m, input int k, input logic [15:0] w);
    logic [199:0] r;
    r = m;
    if (k < NW - 1) r[k*16 +: 16] = w;
    else            r[199:192] = w[15:8];
    return r;
  endfunction

  function automatic logic [15:0] exp_word(input logic [199:0] m, input int k);
    if (k < NW - 1) return m[k*16 +: 16];
    return {m[199:192], 8'h00};
  endfunction

  function automatic bit legal(input logic [1:0] op);
`ifdef MATRIX_SEQ_STORE_EN
    return op <= 2'd2;
`else
    return op <= 2'd1;
`endif
  endfunction

  // MMU responder
  int         resp_mode = 0;
  int         max_wait = 0;
  bit         spurious = 0;
  logic [15:0] pat_base = 16'h0;
  logic [5:0]  cur_base = 6'd0;
  int         wait_cnt = 0;
  bit         req_seen = 0;

  always @(posedge clock) begin
    logic [5:0] off;
    #1;
    if (mem_start) begin
      if (!req_seen) begin
        req_seen = 1;
        wait_cnt = $urandom_range(0, max_wait);
      end
      if (wait_cnt == 0) begin
        off = mem_address - cur_base;
        mem_done = 1'b1;
        mem_data_out = (resp_mode == 0) ? (pat_base + {10'd0, off}) : 16'($urandom);
        req_seen = 0;
      end else begin
        wait_cnt--;
        mem_done = 1'b0;
      end
    end else begin
      req_seen = 0;
      mem_done = spurious && ($urandom_range(0, 3) == 0);
      mem_data_out = 16'($urandom);
    end
  end

  // Reference model: transfer in progress, requesting or pausing, final pulse.
  logic         m_busy = 0, m_req = 0, m_done = 0, m_err = 0;
  int           m_k = 0;
  logic [1:0]   m_op = 0;
  logic [5:0]   m_base = 0;
  logic [199:0] m_snap = '0, m_a = '0, m_b = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_req = 0; m_done = 0; m_err = 0; m_k = 0;
      m_op = 0; m_base = 0; m_snap = '0; m_a = '0; m_b = '0;
    end else begin
      m_err = 0;
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          if (legal(cmd_op)) begin
            m_busy = 1; m_req = 1; m_k = 0; m_op = cmd_op; m_base = cmd_base;
            if (cmd_op == 2'd2) m_snap = matrix_c;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_req) begin
        if (mem_done) begin
          if (m_op == 2'd0)      m_a = put_word(m_a, m_k, mem_data_out);
          else if (m_op == 2'd1) m_b = put_word(m_b, m_k, mem_data_out);
          m_req = 0;
        end
      end else if (m_k == NW - 1) begin
        m_done = 1;
      end else begin
        m_k++;
        m_req = 1;
      end
    end
  end

  // Per-cycle compare plus transaction monitors
  logic [5:0]  hs_addr[$];
  logic [15:0] hs_data[$];
  int acc_cyc = 0, done_cyc = 0, rdy_cyc = -1;
  bit start_seen = 0;

  always @(negedge clock) begin
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("mem_start", mem_start, m_busy && m_req);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("matrix_a", matrix_a, m_a);
    chk("matrix_b", matrix_b, m_b);
    if (m_busy && m_req) begin
      chk("mem_address", mem_address, 6'(m_base + m_k));
`ifdef MATRIX_SEQ_STORE_EN
      chk("mem_write_enabled", mem_write_enabled, m_op == 2'd2);
      if (m_op == 2'd2) chk("mem_data_in", mem_data_in, exp_word(m_snap, m_k));
`endif
    end
`ifndef MATRIX_SEQ_STORE_EN
    chk("mem_write_enabled_tied", mem_write_enabled, 0);
    chk("mem_data_in_tied", mem_data_in, 0);
`endif
    if (mem_start && mem_done) begin
      hs_addr.push_back(mem_address);
      hs_data.push_back(mem_data_in);
    end
    if (mem_start) start_seen = 1;
    if (cmd_valid && cmd_ready) begin
      acc_cyc = cyc;
      rdy_cyc = -1;
    end
    if (done) done_cyc = cyc;
    if (cmd_ready && rdy_cyc < 0 && cyc > acc_cyc) rdy_cyc = cyc;
  end

  task automatic do_cmd(input logic [1:0] op, input logic [5:0] base);
    int n = 0;
    @(posedge clock); #1;
    while (!cmd_ready && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    chk("cmd_ready_timeout", n >= 500, 0);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_base = base;
    cur_base = base;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", n >= 1000, 0);
    @(negedge clock); #1;
  endtask

  task automatic err_test(input logic [1:0] op);
    start_seen = 0;
    do_cmd(op, 6'd33);
    @(negedge clock); #1;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clock); #1;
    chk("err_clear", err, 0);
    chk("err_no_start", start_seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [199:0] pat, a_keep;
    int n;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_base = 6'd0;
    mem_done = 1'b0; mem_data_out = 16'h0; matrix_c = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_start", mem_start, 0);
    chk("rst_mem_we", mem_write_enabled, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_matrix_a", matrix_a, 0);
    chk("rst_matrix_b", matrix_b, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_mem_start", mem_start, 0);

    // LOAD_A from base 0, zero-wait MMU returning A000+k
    pat_base = 16'hA000;
    do_cmd(2'd0, 6'd0);
    wait_idle();
    chk("loadA_w0", matrix_a[15:0], 16'hA000);
    chk("loadA_w1", matrix_a[31:16], 16'hA001);
    chk("loadA_w11", matrix_a[191:176], 16'hA00B);
    chk("loadA_w12", matrix_a[199:192], 8'hA0);
    chk("loadA_b_untouched", matrix_b, 0);
    chk("loadA_done_cycle", done_cyc - acc_cyc, 27);
    chk("loadA_ready_cycle", rdy_cyc - acc_cyc, 28);
    a_keep = matrix_a;

`ifdef MATRIX_SEQ_STORE_EN
    for (int i = 0; i < 25; i++) pat[i*8 +: 8] = 8'(i * 7 + 3);
    matrix_c = pat;
    hs_addr.delete();
    hs_data.delete();
    do_cmd(2'd2, 6'd60);
    matrix_c = ~pat;
    wait_idle();
    chk("store_words", hs_addr.size(), NW);
    if (hs_addr.size() == NW) begin
      for (int k = 0; k < NW; k++) begin
        chk("store_addr", hs_addr[k], (k < 4) ? 60 + k : k - 4);
        if (k < NW - 1) chk("store_data", hs_data[k], pat[k*16 +: 16]);
      end
      chk("store_addr4_wrap", hs_addr[4], 0);
      chk("store_w0", hs_data[0], 16'h0A03);
      chk("store_w12", hs_data[12], 16'hAB00);
    end
`else
    err_test(2'd2);
`endif
    err_test(2'd3);

    // LOAD_B with random waits, spurious done, and a command pulsed while busy
    resp_mode = 1; max_wait = 3; spurious = 1;
    do_cmd(2'd1, 6'($urandom));
    repeat (7) @(posedge clock);
    #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_base = 6'd5;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    wait_idle();
    chk("loadB_a_untouched", matrix_a, a_keep);

    for (int t = 0; t < 8; t++) begin
      matrix_c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_cmd(2'($urandom_range(0, 3)), 6'($urandom));
      matrix_c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      wait_idle();
    end

    // Reset while word 5 of a LOAD_A is being requested
    resp_mode = 0; max_wait = 0; spurious = 0; pat_base = 16'h5500;
    do_cmd(2'd0, 6'd10);
    n = 0;
    while (!(mem_start && mem_address == 6'd15) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("word5_timeout", n >= 200, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_start", mem_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_matrix_a", matrix_a, 0);
    chk("midrst_matrix_b", matrix_b, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    do_cmd(2'd0, 6'd50);
    wait_idle();
    chk("recover_w12", matrix_a[199:192], 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
